// File: rtl/addr_decoder.sv
// Dock I/O address decoder: programmable base/mask windows steer CPU I/O cycles to card slots.
// Decode is combinational; chip selects and bus enables are registered (1 clk), waits merged from slot READY.
module addr_decoder #(
  parameter int ADDR_W    = 8,
  parameter int NUM_WIN   = 4,
  parameter int NUM_SLOTS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 iorq_n,
  input  logic                 r_w_,
  input  logic [NUM_SLOTS-1:0] dev_ready_n,
  input  logic                 irq_int_active,
  input  logic [2:0]           irq_int_slot,
  input  logic                 irq_vec_cycle,
  input  logic                 cfg_clk,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_addr,
  input  logic [7:0]           cfg_wdata,
  output logic                 ready_n,
  output logic                 io_r_w_,
  output logic                 data_oe_n,
  output logic                 data_dir,
  output logic                 ff_oe_n,
  output logic                 win_valid,
  output logic [3:0]           win_index,
  output logic [2:0]           sel_slot,
  output logic [NUM_SLOTS-1:0] cs_n
);

  localparam logic [3:0] SLOTS4 = 4'(NUM_SLOTS);

  logic [ADDR_W-1:0] base_q [NUM_WIN];
  logic [ADDR_W-1:0] mask_q [NUM_WIN];
  logic [2:0]        slot_q [NUM_WIN];
  logic [7:0]        op_q   [NUM_WIN];

  logic [NUM_WIN-1:0]   hit;
  logic [2:0]           win_slot;
  logic                 mapped;
  logic                 rd_eff;
  logic                 active;

  logic [NUM_SLOTS-1:0] cs_n_d, cs_n_q;
  logic                 ready_n_d, ready_n_q;
  logic                 data_oe_n_d, data_oe_n_q;
  logic                 data_dir_d, data_dir_q;
  logic                 ff_oe_n_d, ff_oe_n_q;
  logic                 io_r_w_d, io_r_w_q;

  logic unused_ok;
  assign unused_ok = cfg_clk;

  // Window registers live at cfg_addr = group*NUM_WIN + window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        base_q[i] <= '0;
        mask_q[i] <= (i == NUM_WIN-1) ? '0 : '1;
        slot_q[i] <= 3'd0;
        op_q[i]   <= (i == NUM_WIN-1) ? 8'hFF : 8'h80;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (cfg_addr == 8'(i))             base_q[i] <= cfg_wdata[ADDR_W-1:0];
        if (cfg_addr == 8'(NUM_WIN + i))   mask_q[i] <= cfg_wdata[ADDR_W-1:0];
        if (cfg_addr == 8'(2*NUM_WIN + i)) slot_q[i] <= cfg_wdata[2:0];
        if (cfg_addr == 8'(3*NUM_WIN + i)) op_q[i]   <= cfg_wdata;
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      hit[i] = (((addr ^ base_q[i]) & mask_q[i]) == '0) &&
               ((op_q[i] == 8'hFF) || (op_q[i] == 8'h00 && !r_w_) ||
                (op_q[i] == 8'h01 && r_w_));
    end
  end

  // Scan downward so the lowest matching window is the one left standing.
  always_comb begin
    win_valid = 1'b0;
    win_index = 4'd0;
    win_slot  = 3'd0;
    for (int i = NUM_WIN-1; i >= 0; i--) begin
      if (hit[i]) begin
        win_valid = 1'b1;
        win_index = 4'(i);
        win_slot  = slot_q[i];
      end
    end
  end

  // Vector fetches bypass the windows and go to the interrupting slot as reads.
  assign sel_slot = irq_vec_cycle ? (irq_int_active ? irq_int_slot : 3'd0) : win_slot;
  assign mapped   = irq_vec_cycle ? irq_int_active : win_valid;
  assign rd_eff   = r_w_ | irq_vec_cycle;
  assign active   = !iorq_n && mapped && ({1'b0, sel_slot} < SLOTS4);

  always_comb begin
    cs_n_d      = '1;
    ready_n_d   = 1'b1;
    data_oe_n_d = 1'b1;
    data_dir_d  = 1'b0;
    ff_oe_n_d   = 1'b1;
    io_r_w_d    = 1'b1;
    if (!iorq_n) begin
      io_r_w_d = r_w_;
      if (active) begin
        data_oe_n_d = 1'b0;
        data_dir_d  = rd_eff;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (sel_slot == 3'(s)) begin
            cs_n_d[s] = 1'b0;
            ready_n_d = dev_ready_n[s];
          end
        end
      end else begin
        // Unclaimed reads float high on the bus; drive 0xFF instead.
        ff_oe_n_d = !rd_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_n_q      <= '1;
      ready_n_q   <= 1'b1;
      data_oe_n_q <= 1'b1;
      data_dir_q  <= 1'b0;
      ff_oe_n_q   <= 1'b1;
      io_r_w_q    <= 1'b1;
    end else begin
      cs_n_q      <= cs_n_d;
      ready_n_q   <= ready_n_d;
      data_oe_n_q <= data_oe_n_d;
      data_dir_q  <= data_dir_d;
      ff_oe_n_q   <= ff_oe_n_d;
      io_r_w_q    <= io_r_w_d;
    end
  end

  assign cs_n      = cs_n_q;
  assign ready_n   = ready_n_q;
  assign data_oe_n = data_oe_n_q;
  assign data_dir  = data_dir_q;
  assign ff_oe_n   = ff_oe_n_q;
  assign io_r_w_   = io_r_w_q;

endmodule

// File: tb/tb_addr_decoder.sv
// Bench for addr_decoder: registered outputs checked through an expected-value queue,
// combinational decode outputs checked directly after inputs settle.
module tb_addr_decoder;
  localparam int ADDR_W = 8, NUM_WIN = 4, NUM_SLOTS = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [ADDR_W-1:0]    addr;
  logic                 iorq_n, r_w_;
  logic [NUM_SLOTS-1:0] dev_ready_n;
  logic                 irq_int_active, irq_vec_cycle;
  logic [2:0]           irq_int_slot;
  logic                 cfg_clk, cfg_we;
  logic [7:0]           cfg_addr, cfg_wdata;
  logic                 ready_n, io_r_w_, data_oe_n, data_dir, ff_oe_n, win_valid;
  logic [3:0]           win_index;
  logic [2:0]           sel_slot;
  logic [NUM_SLOTS-1:0] cs_n;

  always #5 clk = ~clk;

  addr_decoder #(.ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .NUM_SLOTS(NUM_SLOTS)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .iorq_n(iorq_n), .r_w_(r_w_),
    .dev_ready_n(dev_ready_n), .irq_int_active(irq_int_active),
    .irq_int_slot(irq_int_slot), .irq_vec_cycle(irq_vec_cycle),
    .cfg_clk(cfg_clk), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .ready_n(ready_n), .io_r_w_(io_r_w_), .data_oe_n(data_oe_n), .data_dir(data_dir),
    .ff_oe_n(ff_oe_n), .win_valid(win_valid), .win_index(win_index),
    .sel_slot(sel_slot), .cs_n(cs_n)
  );

  // full=0: direction/forwarded R/W are left unchecked (unmapped cycles).
  typedef struct packed {
    logic                 full;
    logic [NUM_SLOTS-1:0] cs_n;
    logic                 ready_n, data_oe_n, data_dir, ff_oe_n, io_r_w_;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t e_idle();
    exp_t e;
    e.full = 1'b1; e.cs_n = '1; e.ready_n = 1'b1; e.data_oe_n = 1'b1;
    e.data_dir = 1'b0; e.ff_oe_n = 1'b1; e.io_r_w_ = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_act(input int slot, input logic dir, input logic rw, input logic rdy_n);
    exp_t e;
    e.full = 1'b1; e.cs_n = '1; e.cs_n[slot] = 1'b0; e.ready_n = rdy_n;
    e.data_oe_n = 1'b0; e.data_dir = dir; e.ff_oe_n = 1'b1; e.io_r_w_ = rw;
    return e;
  endfunction

  function automatic exp_t e_unm(input logic rd);
    exp_t e;
    e.full = 1'b0; e.cs_n = '1; e.ready_n = 1'b1; e.data_oe_n = 1'b1;
    e.data_dir = 1'b0; e.ff_oe_n = !rd; e.io_r_w_ = rd;
    return e;
  endfunction

  // Push expectation, clock once, pop and compare, return to the falling edge.
  task automatic step(input string tag, input exp_t e);
    exp_t  x;
    string t;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    t = tag_q.pop_front();
    check_val({t, ".cs_n"},      32'(cs_n),      32'(x.cs_n));
    check_val({t, ".ready_n"},   32'(ready_n),   32'(x.ready_n));
    check_val({t, ".data_oe_n"}, 32'(data_oe_n), 32'(x.data_oe_n));
    check_val({t, ".ff_oe_n"},   32'(ff_oe_n),   32'(x.ff_oe_n));
    if (x.full) begin
      check_val({t, ".data_dir"}, 32'(data_dir), 32'(x.data_dir));
      check_val({t, ".io_r_w_"},  32'(io_r_w_),  32'(x.io_r_w_));
    end
    @(negedge clk);
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic check_dec(input string tag, input logic v, input logic [3:0] idx, input logic [2:0] sl);
    #1;
    check_val({tag, ".win_valid"}, 32'(win_valid), 32'(v));
    check_val({tag, ".win_index"}, 32'(win_index), 32'(idx));
    check_val({tag, ".sel_slot"},  32'(sel_slot),  32'(sl));
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; iorq_n = 1'b1; r_w_ = 1'b1; dev_ready_n = '1;
    irq_int_active = 1'b0; irq_int_slot = 3'd0; irq_vec_cycle = 1'b0;
    cfg_clk = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    @(negedge clk);
    step("rst0", e_idle());
    step("rst1", e_idle());
    addr = 8'h10;
    check_dec("rst_catchall", 1'b1, 4'd3, 3'd0);
    rst_n = 1'b1;

    // win0: 0x10 exact, slot 0, any direction
    cfg_wr(8'd0, 8'h10); cfg_wr(8'd4, 8'hFF); cfg_wr(8'd8, 8'd0); cfg_wr(8'd12, 8'hFF);
    addr = 8'h10; r_w_ = 1'b0; iorq_n = 1'b0;
    check_dec("wr10", 1'b1, 4'd0, 3'd0);
    step("wr10", e_act(0, 1'b0, 1'b0, 1'b1));
    iorq_n = 1'b1;
    step("wr10_end", e_idle());

    // win2: 0x3x read-only, slot 1; slot 1 busy for several clocks
    cfg_wr(8'd2, 8'h30); cfg_wr(8'd6, 8'hF0); cfg_wr(8'd10, 8'd1); cfg_wr(8'd14, 8'h01);
    addr = 8'h31; r_w_ = 1'b1; iorq_n = 1'b0; dev_ready_n = 5'b11101;
    check_dec("rd31", 1'b1, 4'd2, 3'd1);
    for (int k = 0; k < 4; k++) step("rd31_wait", e_act(1, 1'b1, 1'b1, 1'b0));
    dev_ready_n = '1;
    step("rd31_rel", e_act(1, 1'b1, 1'b1, 1'b1));
    iorq_n = 1'b1;
    step("rd31_end", e_idle());

    // last window narrowed to 0x00 only: 0x77 falls through every window
    cfg_wr(8'd7, 8'hFF); cfg_wr(8'd3, 8'h00);
    addr = 8'h77; r_w_ = 1'b1; iorq_n = 1'b0;
    check_dec("rd77", 1'b0, 4'd0, 3'd0);
    step("rd77", e_unm(1'b1));
    r_w_ = 1'b0;
    step("wr77", e_unm(1'b0));
    iorq_n = 1'b1;
    step("rd77_end", e_idle());

    // win1: 0x2x write-only, slot 1; config write issued during an active cycle
    addr = 8'h25; r_w_ = 1'b0; iorq_n = 1'b0;
    cfg_we = 1'b1; cfg_addr = 8'd1; cfg_wdata = 8'h20;
    step("wr25_pre", e_unm(1'b0));
    cfg_wr(8'd5, 8'hF0); cfg_wr(8'd9, 8'd1); cfg_wr(8'd13, 8'h00);
    iorq_n = 1'b1; r_w_ = 1'b1;
    step("cfg_gap", e_idle());
    iorq_n = 1'b0;
    check_dec("rd25", 1'b0, 4'd0, 3'd0);
    step("rd25", e_unm(1'b1));
    r_w_ = 1'b0;
    check_dec("wr25", 1'b1, 4'd1, 3'd1);
    step("wr25", e_act(1, 1'b0, 1'b0, 1'b1));
    iorq_n = 1'b1;
    step("wr25_end", e_idle());

    // vector fetch owned by slot 3, then reset in the middle of it
    irq_vec_cycle = 1'b1; irq_int_active = 1'b1; irq_int_slot = 3'd3;
    r_w_ = 1'b1; iorq_n = 1'b0; addr = 8'h77;
    #1 check_val("vec.sel_slot", 32'(sel_slot), 32'd3);
    step("vec", e_act(3, 1'b1, 1'b1, 1'b1));
    rst_n = 1'b0;
    step("vec_rst", e_idle());
    rst_n = 1'b1;
    irq_int_active = 1'b0;
    step("vec_noint", e_unm(1'b1));

    // after reset the catch-all window is back and routes to slot 0
    irq_vec_cycle = 1'b0; addr = 8'h55; r_w_ = 1'b1;
    check_dec("rd55", 1'b1, 4'd3, 3'd0);
    step("rd55", e_act(0, 1'b1, 1'b1, 1'b1));
    iorq_n = 1'b1;
    step("final", e_idle());

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
